// File: rtl/alu_operand_stage_if.sv
// Handshake and payload bundle for the operand stage.
//   decode side : dec_valid/dec_ready plus the decoded micro-op fields
//   execute side: ex_valid/ex_ready plus ALU operands, command and writeback tag
// master = pipeline environment (decoder + ALU), slave = alu_operand_stage.
interface alu_operand_stage_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
);
  // decode -> stage
  logic                 dec_valid;
  logic                 dec_ready;
  logic [REG_IDX_W-1:0] dec_rs1_idx;
  logic [REG_IDX_W-1:0] dec_rs2_idx;
  logic [XLEN-1:0]      dec_rs1_val;
  logic [XLEN-1:0]      dec_rs2_val;
  logic [XLEN-1:0]      dec_imm;
  logic [XLEN-1:0]      dec_pc;
  logic                 dec_src1_pc;
  logic                 dec_src2_imm;
  logic [2:0]           dec_alu_cmd;
  logic [REG_IDX_W-1:0] dec_rd_idx;
  logic                 dec_wb_en;
  // stage -> execute
  logic                 ex_valid;
  logic                 ex_ready;
  logic [XLEN-1:0]      alu_in1;
  logic [XLEN-1:0]      alu_in2;
  logic [2:0]           alu_command;
  logic [REG_IDX_W-1:0] ex_rd_idx;
  logic                 ex_wb_en;

  modport master (
    output dec_valid, dec_rs1_idx, dec_rs2_idx, dec_rs1_val, dec_rs2_val,
           dec_imm, dec_pc, dec_src1_pc, dec_src2_imm, dec_alu_cmd,
           dec_rd_idx, dec_wb_en, ex_ready,
    input  dec_ready, ex_valid, alu_in1, alu_in2, alu_command, ex_rd_idx,
           ex_wb_en
  );

  modport slave (
    input  dec_valid, dec_rs1_idx, dec_rs2_idx, dec_rs1_val, dec_rs2_val,
           dec_imm, dec_pc, dec_src1_pc, dec_src2_imm, dec_alu_cmd,
           dec_rd_idx, dec_wb_en, ex_ready,
    output dec_ready, ex_valid, alu_in1, alu_in2, alu_command, ex_rd_idx,
           ex_wb_en
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode->execute boundary register in front of the ALU.
// A 2-entry skid buffer (main M, skid S) keeps dec_ready a pure flop output
// while sustaining one op per cycle; M drives alu_in1/alu_in2/alu_command.
// Ports: clk, rst_n (async, active-low), i_flush (sync kill of held ops),
//   i_mem_fwd_* / i_wb_fwd_* (MEM and WB result buses),
//   bus (alu_operand_stage_if.slave: decode handshake in, execute handshake out).
// Build option ALU_OPERAND_FWD_EN: when defined, operands are forwarded at
//   capture and held operands snoop the result buses (MEM beats WB, x0 never
//   matches). When undefined the forward ports are ignored and decode must
//   interlock RAW hazards itself.
module alu_operand_stage #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_mem_fwd_valid,
  input  logic [REG_IDX_W-1:0] i_mem_fwd_rd,
  input  logic [XLEN-1:0]      i_mem_fwd_val,
  input  logic                 i_wb_fwd_valid,
  input  logic [REG_IDX_W-1:0] i_wb_fwd_rd,
  input  logic [XLEN-1:0]      i_wb_fwd_val,
  alu_operand_stage_if.slave   bus
);

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic                 src1_pc;
    logic                 src2_imm;
    logic [2:0]           alu_cmd;
    logic [REG_IDX_W-1:0] rd_idx;
    logic                 wb_en;
  } op_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t r_state;
  logic   r_m_vld;
  logic   r_s_vld;
  op_t    r_m;
  op_t    r_s;

  logic   w_accept;
  logic   w_drain;
  op_t    w_dec_op;   // incoming op with capture forwarding applied
  op_t    w_s_op;     // S with snoop applied, used for the S->M move
  logic [XLEN-1:0] w_m_rs1, w_m_rs2, w_s_rs1, w_s_rs2;
  logic [XLEN-1:0] w_dec_rs1, w_dec_rs2;

`ifdef ALU_OPERAND_FWD_EN
  // MEM is younger than WB, so it wins when both match the same index.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_IDX_W-1:0] idx,
    input logic [XLEN-1:0]      cur
  );
    fwd_sel = cur;
    if (idx != '0) begin
      if (i_mem_fwd_valid && (i_mem_fwd_rd == idx))
        fwd_sel = i_mem_fwd_val;
      else if (i_wb_fwd_valid && (i_wb_fwd_rd == idx))
        fwd_sel = i_wb_fwd_val;
    end
  endfunction

  always_comb begin
    w_dec_rs1 = fwd_sel(bus.dec_rs1_idx, bus.dec_rs1_val);
    w_dec_rs2 = fwd_sel(bus.dec_rs2_idx, bus.dec_rs2_val);
    w_m_rs1   = fwd_sel(r_m.rs1_idx, r_m.rs1);
    w_m_rs2   = fwd_sel(r_m.rs2_idx, r_m.rs2);
    w_s_rs1   = fwd_sel(r_s.rs1_idx, r_s.rs1);
    w_s_rs2   = fwd_sel(r_s.rs2_idx, r_s.rs2);
  end
`else
  always_comb begin
    w_dec_rs1 = bus.dec_rs1_val;
    w_dec_rs2 = bus.dec_rs2_val;
    w_m_rs1   = r_m.rs1;
    w_m_rs2   = r_m.rs2;
    w_s_rs1   = r_s.rs1;
    w_s_rs2   = r_s.rs2;
  end

  // Forward buses and M's source indices only matter when forwarding is built in.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_mem_fwd_valid, i_mem_fwd_rd, i_mem_fwd_val,
                          i_wb_fwd_valid, i_wb_fwd_rd, i_wb_fwd_val,
                          r_m.rs1_idx, r_m.rs2_idx};
`endif

  always_comb begin
    w_dec_op.rs1_idx  = bus.dec_rs1_idx;
    w_dec_op.rs2_idx  = bus.dec_rs2_idx;
    w_dec_op.rs1      = w_dec_rs1;
    w_dec_op.rs2      = w_dec_rs2;
    w_dec_op.imm      = bus.dec_imm;
    w_dec_op.pc       = bus.dec_pc;
    w_dec_op.src1_pc  = bus.dec_src1_pc;
    w_dec_op.src2_imm = bus.dec_src2_imm;
    w_dec_op.alu_cmd  = bus.dec_alu_cmd;
    w_dec_op.rd_idx   = bus.dec_rd_idx;
    w_dec_op.wb_en    = bus.dec_wb_en;

    w_s_op     = r_s;
    w_s_op.rs1 = w_s_rs1;
    w_s_op.rs2 = w_s_rs2;
  end

  // dec_ready is ~S.valid, so no accept can happen while both entries are full.
  assign w_accept = bus.dec_valid & ~r_s_vld;
  assign w_drain  = r_m_vld & bus.ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
      r_m     <= '0;
      r_s     <= '0;
    end else if (i_flush) begin
      // Flush overrides accept, drain and snoop; the offered op is dropped.
      r_state <= ST_EMPTY;
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else begin
      // Held operands track the result buses every cycle; a load below
      // overrides these with the freshly captured/moved op.
      r_m.rs1 <= w_m_rs1;
      r_m.rs2 <= w_m_rs2;
      r_s.rs1 <= w_s_rs1;
      r_s.rs2 <= w_s_rs2;
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m     <= w_dec_op;
            r_m_vld <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            r_m <= w_dec_op;
          end else if (w_accept) begin
            r_s     <= w_dec_op;
            r_s_vld <= 1'b1;
            r_state <= ST_TWO;
          end else if (w_drain) begin
            r_m_vld <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            r_m     <= w_s_op;
            r_s_vld <= 1'b0;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_m_vld <= 1'b0;
          r_s_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dec_ready   = ~r_s_vld;
  assign bus.ex_valid    = r_m_vld;
  assign bus.alu_in1     = r_m.src1_pc  ? r_m.pc  : r_m.rs1;
  assign bus.alu_in2     = r_m.src2_imm ? r_m.imm : r_m.rs2;
  assign bus.alu_command = r_m.alu_cmd;
  assign bus.ex_rd_idx   = r_m.rd_idx;
  assign bus.ex_wb_en    = r_m.wb_en & r_m_vld;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_val;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_val;

  int n_checks = 0;
  int n_fail   = 0;

  alu_operand_stage_if #(.XLEN(32), .REG_IDX_W(5)) bus ();

  alu_operand_stage #(.XLEN(32), .REG_IDX_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_flush         (flush),
    .i_mem_fwd_valid (mem_fwd_valid),
    .i_mem_fwd_rd    (mem_fwd_rd),
    .i_mem_fwd_val   (mem_fwd_val),
    .i_wb_fwd_valid  (wb_fwd_valid),
    .i_wb_fwd_rd     (wb_fwd_rd),
    .i_wb_fwd_val    (wb_fwd_val),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op on the decode bus (dec_valid=1).
  task automatic drive_op(input logic [4:0] rs1i, input logic [31:0] rs1v,
                          input logic [4:0] rs2i, input logic [31:0] rs2v,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic s1pc, input logic s2imm,
                          input logic [2:0] cmd, input logic [4:0] rd);
    bus.dec_valid    = 1'b1;
    bus.dec_rs1_idx  = rs1i;
    bus.dec_rs1_val  = rs1v;
    bus.dec_rs2_idx  = rs2i;
    bus.dec_rs2_val  = rs2v;
    bus.dec_imm      = imm;
    bus.dec_pc       = pc;
    bus.dec_src1_pc  = s1pc;
    bus.dec_src2_imm = s2imm;
    bus.dec_alu_cmd  = cmd;
    bus.dec_rd_idx   = rd;
    bus.dec_wb_en    = 1'b1;
  endtask

  task automatic clear_fwd();
    mem_fwd_valid = 1'b0;
    mem_fwd_rd    = '0;
    mem_fwd_val   = '0;
    wb_fwd_valid  = 1'b0;
    wb_fwd_rd     = '0;
    wb_fwd_val    = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    clear_fwd();
    bus.ex_ready = 1'b0;
    drive_op(5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0);
    bus.dec_valid = 1'b0;

    // ---- reset state
    tick();
    tick();
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_dec_ready", {31'd0, bus.dec_ready}, 32'd1);
    chk("rst_alu_in1", bus.alu_in1, 32'd0);
    chk("rst_alu_in2", bus.alu_in2, 32'd0);
    chk("rst_cmd", {29'd0, bus.alu_command}, 32'd0);
    chk("rst_wb_en", {31'd0, bus.ex_wb_en}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- back-to-back with ex_ready=1
    bus.ex_ready = 1'b1;
    drive_op(5'd1, 32'h500, 5'd2, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd4);
    tick();
    chk("b2b_add_vld", {31'd0, bus.ex_valid}, 32'd1);
    chk("b2b_add_in1", bus.alu_in1, 32'h500);
    chk("b2b_add_in2", bus.alu_in2, 32'h100);
    chk("b2b_add_cmd", {29'd0, bus.alu_command}, 32'd0);
    chk("b2b_add_rd", {27'd0, bus.ex_rd_idx}, 32'd4);
    chk("b2b_add_wb", {31'd0, bus.ex_wb_en}, 32'd1);
    chk("b2b_add_rdy", {31'd0, bus.dec_ready}, 32'd1);
    drive_op(5'd3, 32'h700, 5'd2, 32'h100, 32'h44, 32'h0, 1'b0, 1'b1, 3'd1, 5'd6);
    tick();
    chk("b2b_sub_in1", bus.alu_in1, 32'h700);
    chk("b2b_sub_in2", bus.alu_in2, 32'h44);
    chk("b2b_sub_cmd", {29'd0, bus.alu_command}, 32'd1);
    chk("b2b_sub_rdy", {31'd0, bus.dec_ready}, 32'd1);
    bus.dec_valid = 1'b0;
    tick();
    chk("b2b_drained", {31'd0, bus.ex_valid}, 32'd0);
    chk("b2b_wb_off", {31'd0, bus.ex_wb_en}, 32'd0);

    // ---- back-pressure: fill M and S, then drain one
    bus.ex_ready = 1'b0;
    drive_op(5'd1, 32'h3, 5'd2, 32'h3, 32'h0, 32'h1000, 1'b1, 1'b0, 3'd2, 5'd7);
    tick();
    chk("bp_a_in1", bus.alu_in1, 32'h1000);
    chk("bp_a_rdy", {31'd0, bus.dec_ready}, 32'd1);
    drive_op(5'd1, 32'h9, 5'd2, 32'hA, 32'h0, 32'h2000, 1'b0, 1'b0, 3'd3, 5'd8);
    tick();
    chk("bp_full_rdy", {31'd0, bus.dec_ready}, 32'd0);
    chk("bp_hold_in1", bus.alu_in1, 32'h1000);
    // op C offered while full must not be taken
    drive_op(5'd1, 32'hC0C0, 5'd2, 32'hC1C1, 32'h0, 32'h3000, 1'b0, 1'b0, 3'd4, 5'd9);
    tick();
    chk("bp_stall_cmd", {29'd0, bus.alu_command}, 32'd2);
    chk("bp_stall_rdy", {31'd0, bus.dec_ready}, 32'd0);
    bus.dec_valid = 1'b0;
    bus.ex_ready  = 1'b1;
    tick();
    chk("bp_b_in1", bus.alu_in1, 32'h9);
    chk("bp_b_in2", bus.alu_in2, 32'hA);
    chk("bp_b_cmd", {29'd0, bus.alu_command}, 32'd3);
    chk("bp_b_rdy", {31'd0, bus.dec_ready}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, bus.ex_valid}, 32'd0);

    // ---- flush beats accept in TWO
    bus.ex_ready = 1'b0;
    drive_op(5'd1, 32'hD, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd5, 5'd1);
    tick();
    drive_op(5'd1, 32'hE, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd6, 5'd1);
    tick();
    chk("fl_full_rdy", {31'd0, bus.dec_ready}, 32'd0);
    flush = 1'b1;
    drive_op(5'd1, 32'hDEAD, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd7, 5'd1);
    tick();
    chk("fl_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("fl_dec_ready", {31'd0, bus.dec_ready}, 32'd1);
    flush = 1'b0;
    bus.dec_valid = 1'b0;
    bus.ex_ready  = 1'b1;
    tick();
    chk("fl_dropped", {31'd0, bus.ex_valid}, 32'd0);

    // ---- asynchronous reset while TWO
    bus.ex_ready = 1'b0;
    drive_op(5'd1, 32'h123, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd1, 5'd1);
    tick();
    drive_op(5'd1, 32'h456, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd1, 5'd1);
    tick();
    chk("ar_pre_in1", bus.alu_in1, 32'h123);
    bus.dec_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ar_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("ar_dec_ready", {31'd0, bus.dec_ready}, 32'd1);
    chk("ar_alu_in1", bus.alu_in1, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- capture forwarding priority: MEM over WB
    bus.ex_ready = 1'b0;
    drive_op(5'd5, 32'h1, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd2);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_val = 32'hAA;
    wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd5; wb_fwd_val  = 32'hBB;
    tick();
    chk("fwd_cap_in1", bus.alu_in1, FWD ? 32'hAA : 32'h1);
    bus.dec_valid = 1'b0;
    // hold snoop with both buses matching
    mem_fwd_val = 32'hC1;
    wb_fwd_val  = 32'hC2;
    tick();
    chk("fwd_snoop_prio", bus.alu_in1, FWD ? 32'hC1 : 32'h1);
    clear_fwd();
    bus.ex_ready = 1'b1;
    tick();
    bus.ex_ready = 1'b0;

    // ---- snoop: x0 never matches, x3 does
    drive_op(5'd0, 32'h0, 5'd0, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd2);
    tick();
    bus.dec_valid = 1'b0;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_val = 32'hFF;
    tick();
    chk("snoop_x0_in2", bus.alu_in2, 32'h22);
    clear_fwd();
    bus.ex_ready = 1'b1;
    tick();
    bus.ex_ready = 1'b0;
    drive_op(5'd0, 32'h0, 5'd3, 32'h33, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 5'd2);
    tick();
    chk("snoop_x3_pre", bus.alu_in2, 32'h33);
    bus.dec_valid = 1'b0;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_val = 32'hFF;
    tick();
    chk("snoop_x3_in2", bus.alu_in2, FWD ? 32'hFF : 32'h33);
    clear_fwd();
    bus.ex_ready = 1'b1;
    tick();
    bus.ex_ready = 1'b0;

    // ---- snoop of S carried over on the S->M move
    drive_op(5'd1, 32'h10, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 5'd2);
    tick();
    drive_op(5'd7, 32'h70, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd4, 5'd2);
    tick();
    bus.dec_valid = 1'b0;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_val = 32'h77;
    tick();
    clear_fwd();
    chk("snoop_s_hold_m", bus.alu_in1, 32'h10);
    bus.ex_ready = 1'b1;
    tick();
    chk("snoop_s_move_cmd", {29'd0, bus.alu_command}, 32'd4);
    chk("snoop_s_move_in1", bus.alu_in1, FWD ? 32'h77 : 32'h70);
    tick();
    chk("final_empty", {31'd0, bus.ex_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
